// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared encodings for the CPU memory arbiter: FSM states, transaction owner
// and a small width helper.
package cpu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // Bits needed to hold 0..max inclusive.
    function automatic int unsigned cnt_width(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter_arb_prio_starve.sv
// LS-priority grant with an anti-starvation counter that forces an IF grant
// after STARVE_MAX consecutive LS grants while IF is waiting.
module cpu_mem_arbiter_arb_prio_starve
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic if_valid,
    input  logic ls_valid,
    output logic grant_if_c,
    output logic grant_ls_c
);

    localparam int unsigned CNT_W = cnt_width(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;

    always_comb begin
        starve_hit = (starve_cnt == CNT_W'(STARVE_MAX)) && if_valid;
        grant_ls_c = ls_valid && !starve_hit;
        grant_if_c = if_valid && !grant_ls_c;
    end

    // Only IDLE cycles are arbitration cycles; the count is frozen otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (idle) begin
            if (grant_ls_c && if_valid) begin
                if (starve_cnt != CNT_W'(STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction at a time, with registered response routing to the owner.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_rdata,
    input  logic                ls_req_valid,
    input  logic                ls_req_we,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wstrb,
    output logic                ls_req_ready,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_rdata,
    output logic                mem_req_valid,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    output logic                err
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e              state_q, state_d;
    owner_e              owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                grant_if_c, grant_ls_c;
    logic                accept_c;

    cpu_mem_arbiter_arb_prio_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .idle       (state_q == ST_IDLE),
        .if_valid   (if_req_valid),
        .ls_valid   (ls_req_valid),
        .grant_if_c (grant_if_c),
        .grant_ls_c (grant_ls_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state plus the handshake outputs decoded from the current state.
    always_comb begin
        state_d       = state_q;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        accept_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if_req_ready = grant_if_c && !rst;
                ls_req_ready = grant_ls_c && !rst;
                accept_c     = grant_if_c || grant_ls_c;
                if (accept_c) state_d = ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Payload captured at the accept edge; IF fetches are always reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept_c) begin
            if (grant_ls_c) begin
                owner_q <= OWN_LS;
                we_q    <= ls_req_we;
                addr_q  <= ls_req_addr;
                wdata_q <= ls_req_wdata;
                wstrb_q <= ls_req_wstrb;
            end else begin
                owner_q <= OWN_IF;
                we_q    <= 1'b0;
                addr_q  <= if_req_addr;
                wdata_q <= '0;
                wstrb_q <= '0;
            end
        end
    end

    always_comb begin
        mem_req_we    = we_q;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
        mem_req_wstrb = wstrb_q;
    end

    // Response routed to the owner one cycle after it arrives; rdata is
    // zero outside the pulse and on store acks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rsp_valid <= 1'b0;
            if_rsp_rdata <= '0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_rdata <= '0;
            err          <= 1'b0;
        end else begin
            if_rsp_valid <= 1'b0;
            if_rsp_rdata <= '0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_rdata <= '0;
            if (mem_rsp_valid) begin
                if (state_q == ST_WAIT) begin
                    if (owner_q == OWN_IF) begin
                        if_rsp_valid <= 1'b1;
                        if_rsp_rdata <= mem_rsp_rdata;
                    end else begin
                        ls_rsp_valid <= 1'b1;
                        ls_rsp_rdata <= we_q ? '0 : mem_rsp_rdata;
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter with a small behavioural memory that
// has configurable ready stalls and response delay.
module tb_cpu_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_rdata;
    logic        ls_req_valid;
    logic        ls_req_we;
    logic [31:0] ls_req_addr;
    logic [31:0] ls_req_wdata;
    logic [3:0]  ls_req_wstrb;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        err;

    cpu_mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_rdata  (if_rsp_rdata),
        .ls_req_valid  (ls_req_valid),
        .ls_req_we     (ls_req_we),
        .ls_req_addr   (ls_req_addr),
        .ls_req_wdata  (ls_req_wdata),
        .ls_req_wstrb  (ls_req_wstrb),
        .ls_req_ready  (ls_req_ready),
        .ls_rsp_valid  (ls_rsp_valid),
        .ls_rsp_rdata  (ls_rsp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .err           (err)
    );

    int checks;
    int failures;
    int cyc;

    // Memory model controls (written by the main thread only).
    int mem_wait;
    int rsp_delay;
    int inject_req;

    // Memory model observations (written by the model only).
    int          inject_ack;
    int          last_len;
    bit          last_chg;
    logic        last_we;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic [3:0]  last_wstrb;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h0050_0093;
            32'h0000_0300: return 32'h1234_5678;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Behavioural memory: stalls ready for mem_wait cycles, answers rsp_delay
    // cycles after acceptance, returns all-ones on writes.
    initial begin
        int          wcnt, dly_cnt, cur_len;
        bit          cur_chg, rsp_pend, pend_we;
        logic [31:0] pend_addr;
        logic        cap_we;
        logic [31:0] cap_addr, cap_wdata;
        logic [3:0]  cap_wstrb;
        wcnt = 0; dly_cnt = 0; cur_len = 0; cur_chg = 0; rsp_pend = 0;
        pend_we = 0; pend_addr = '0; cap_we = 0; cap_addr = '0;
        cap_wdata = '0; cap_wstrb = '0;
        inject_ack = 0; last_len = 0; last_chg = 0; last_we = 0;
        last_addr = '0; last_wdata = '0; last_wstrb = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = '0;
            if (inject_req != inject_ack) begin
                inject_ack++;
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = 32'hBAD0_0000;
            end else if (rsp_pend) begin
                if (dly_cnt >= rsp_delay) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = pend_we ? 32'hFFFF_FFFF : rdata_for(pend_addr);
                    rsp_pend = 0;
                end else begin
                    dly_cnt++;
                end
            end
            if (mem_req_valid) begin
                if (cur_len == 0) begin
                    cap_we = mem_req_we; cap_addr = mem_req_addr;
                    cap_wdata = mem_req_wdata; cap_wstrb = mem_req_wstrb;
                end else if (mem_req_we !== cap_we || mem_req_addr !== cap_addr ||
                             mem_req_wdata !== cap_wdata || mem_req_wstrb !== cap_wstrb) begin
                    cur_chg = 1;
                end
                cur_len++;
                if (wcnt >= mem_wait) begin
                    mem_req_ready = 1'b1;
                    wcnt = 0;
                    rsp_pend = 1; dly_cnt = 0;
                    pend_we = cap_we; pend_addr = cap_addr;
                    last_len = cur_len; last_chg = cur_chg;
                    last_we = cap_we; last_addr = cap_addr;
                    last_wdata = cap_wdata; last_wstrb = cap_wstrb;
                    cur_len = 0; cur_chg = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // One request through to its response; returns rdata and accept-to-rsp latency.
    task automatic do_txn(input bit is_ls, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input string tag, output logic [31:0] rdata, output int lat);
        int t_acc;
        bit got, other;
        @(posedge clk); #1;
        if (is_ls) begin
            ls_req_valid = 1'b1; ls_req_we = we; ls_req_addr = addr;
            ls_req_wdata = wdata; ls_req_wstrb = wstrb;
        end else begin
            if_req_valid = 1'b1; if_req_addr = addr;
        end
        got = 0; t_acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (is_ls ? ls_req_ready : if_req_ready) begin
                got = 1; t_acc = cyc;
                break;
            end
        end
        check({tag, "_accept"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        ls_req_valid = 1'b0;
        if_req_valid = 1'b0;
        got = 0; other = 0; lat = -1; rdata = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (is_ls ? if_rsp_valid : ls_rsp_valid) other = 1;
            if (is_ls ? ls_rsp_valid : if_rsp_valid) begin
                got = 1; lat = cyc - t_acc;
                rdata = is_ls ? ls_rsp_rdata : if_rsp_rdata;
                break;
            end
        end
        check({tag, "_rsp_seen"}, 32'(got), 32'd1);
        check({tag, "_nonowner_rsp"}, 32'(other), 32'd0);
        @(negedge clk);
        check({tag, "_pulse_1cyc"}, 32'(is_ls ? ls_rsp_valid : if_rsp_valid), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_ready"}, 32'(if_req_ready), 32'd0);
        check({tag, "_ls_ready"}, 32'(ls_req_ready), 32'd0);
        check({tag, "_rsp_valids"}, 32'({if_rsp_valid, ls_rsp_valid}), 32'd0);
        check({tag, "_rsp_rdata"}, if_rsp_rdata | ls_rsp_rdata, 32'd0);
        check({tag, "_mem_req"}, 32'({mem_req_valid, mem_req_we}), 32'd0);
        check({tag, "_mem_addr"}, mem_req_addr | mem_req_wdata, 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          seen, hi, lo, if_done;
        bit          grants[$];
        bit          exp_g[6];
        checks = 0; failures = 0;
        mem_wait = 0; rsp_delay = 0; inject_req = 0;
        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = '0;
        ls_req_wdata = '0; ls_req_wstrb = '0;
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // IF fetch, minimum latency.
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, "if_fetch", rd, lat);
        check("if_fetch_rdata", rd, 32'h0050_0093);
        check("if_fetch_latency", 32'(lat), 32'd3);
        check("if_fetch_mem_addr", last_addr, 32'h10);

        // LS store with two ready stalls.
        mem_wait = 2;
        do_txn(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, "ls_store", rd, lat);
        check("ls_store_rdata", rd, 32'h0);
        check("ls_store_latency", 32'(lat), 32'd5);
        check("ls_store_req_len", 32'(last_len), 32'd3);
        check("ls_store_req_stable", 32'(last_chg), 32'd0);
        check("ls_store_we", 32'(last_we), 32'd1);
        check("ls_store_addr", last_addr, 32'h200);
        check("ls_store_wdata", last_wdata, 32'hDEAD_BEEF);
        check("ls_store_wstrb", 32'(last_wstrb), 32'hF);
        mem_wait = 0;

        // Both valid, LS reissuing: four LS grants then IF.
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_addr = 32'h40;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h80;
        ls_req_wdata = '0; ls_req_wstrb = '0;
        if_done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("both_valid_if_ready", 32'(if_req_ready), 32'd0);
                check("both_valid_ls_ready", 32'(ls_req_ready), 32'd1);
            end
            if (if_req_valid && if_req_ready) begin
                grants.push_back(1'b0);
                if_done = 1;
            end
            if (ls_req_valid && ls_req_ready) grants.push_back(1'b1);
            if (grants.size() >= 6) break;
            @(posedge clk); #1;
            if (if_done) if_req_valid = 1'b0;
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        check("starve_grant_count", 32'(grants.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("starve_grant%0d", k),
                  32'((k < grants.size()) ? grants[k] : 1'bx), 32'(exp_g[k]));
        end
        repeat (10) @(negedge clk);
        check("err_clean_before_idle_rsp", 32'(err), 32'd0);

        // Unsolicited response while idle.
        @(posedge clk); #1;
        inject_req++;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if_rsp_valid || ls_rsp_valid) seen = 1;
        end
        check("idle_rsp_no_pulse", 32'(seen), 32'd0);
        check("idle_rsp_err", 32'(err), 32'd1);
        repeat (5) @(negedge clk);
        check("idle_rsp_err_sticky", 32'(err), 32'd1);

        // Reset while a load waits for its response.
        rsp_delay = 3;
        @(posedge clk); #1;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h300;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ls_req_ready) begin seen = 1; break; end
        end
        check("rstwait_accept", 32'(seen), 32'd1);
        @(posedge clk); #1;
        ls_req_valid = 1'b0;
        hi = 0; lo = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req_valid) hi = 1;
            else if (hi) begin lo = 1; break; end
        end
        check("rstwait_reached_wait", 32'(lo), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_in_wait");
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ls_rsp_valid || if_rsp_valid) seen = 1;
        end
        check("rstwait_no_rsp", 32'(seen), 32'd0);
        check("rstwait_late_err", 32'(err), 32'd1);
        check("rstwait_idle", 32'(mem_req_valid), 32'd0);
        rsp_delay = 0;

        // Plain load after recovery.
        do_txn(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, "ls_load", rd, lat);
        check("ls_load_rdata", rd, 32'h1234_5678);
        check("ls_load_latency", 32'(lat), 32'd3);
        check("ls_load_we", 32'(last_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
